// File: rtl/read_channel_distributor.sv
// read_channel_distributor
//   Buffers tagged SRAM read beats in a small FIFO and presents the head beat
//   on exactly one of num_of_ports output channels (valid/ready per channel).
//   Ordering is strict FIFO across all ports, so a stalled head blocks the rest.
//   Optional build macro: READ_DISTRIBUTOR_STATS_EN adds per-channel
//   saturating pop counters readable through stat_sel / stat_count.
//   fifo_depth must be a power of 2 and at least 2.
module read_channel_distributor #(
  parameter int data_width   = 256,
  parameter int num_of_ports = 16,
  parameter int port_width   = 4,
  parameter int fifo_depth   = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [port_width-1:0]                in_port,
  input  logic [data_width-1:0]                in_data,
  output logic [num_of_ports*data_width-1:0]   out_data,
  output logic [num_of_ports-1:0]              out_valid,
  input  logic [num_of_ports-1:0]              out_ready,
  output logic [port_width-1:0]                out_port,
  output logic                                 busy
`ifdef READ_DISTRIBUTOR_STATS_EN
  ,
  input  logic [port_width-1:0]                stat_sel,
  output logic [15:0]                          stat_count
`endif
);

  localparam int ptr_w = $clog2(fifo_depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0]      depth_c = cnt_w'(fifo_depth);
  localparam logic [port_width:0]   ports_c = (port_width+1)'(num_of_ports);

  logic [data_width-1:0] data_mem_r [fifo_depth];
  logic [port_width-1:0] port_mem_r [fifo_depth];
  logic [ptr_w-1:0]      wr_ptr_r;
  logic [ptr_w-1:0]      rd_ptr_r;
  logic [cnt_w-1:0]      count_r;

  logic                  full_s;
  logic                  empty_s;
  logic                  tag_ok_s;
  logic                  push_s;
  logic                  pop_s;
  logic [port_width-1:0] head_port_s;
  logic [data_width-1:0] head_data_s;

  assign full_s      = (count_r == depth_c);
  assign empty_s     = (count_r == {cnt_w{1'b0}});
  assign head_port_s = port_mem_r[rd_ptr_r];
  assign head_data_s = data_mem_r[rd_ptr_r];

  // Tags outside the channel range are silently dropped at the input.
  assign tag_ok_s    = ({1'b0, in_port} < ports_c);
  assign push_s      = in_valid && !full_s && tag_ok_s;
  // Only the ready of the channel owning the head beat matters.
  assign pop_s       = !empty_s && out_ready[head_port_s];

  assign in_ready    = !full_s;
  assign busy        = !empty_s;

  // Pointer and occupancy bookkeeping; reset discards every buffered beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {ptr_w{1'b0}};
      rd_ptr_r <= {ptr_w{1'b0}};
      count_r  <= {cnt_w{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Beat storage; contents are meaningless while the slot is not occupied.
  always_ff @(posedge clk) begin
    if (push_s) begin
      data_mem_r[wr_ptr_r] <= in_data;
      port_mem_r[wr_ptr_r] <= in_port;
    end
  end

  // Steer the head beat onto its channel; everything else is held at zero.
  always_comb begin
    out_valid = {num_of_ports{1'b0}};
    out_data  = {(num_of_ports*data_width){1'b0}};
    out_port  = {port_width{1'b0}};
    if (!empty_s) begin
      out_valid[head_port_s]                          = 1'b1;
      out_data[head_port_s*data_width +: data_width]  = head_data_s;
      out_port                                        = head_port_s;
    end else begin
      out_valid = {num_of_ports{1'b0}};
      out_data  = {(num_of_ports*data_width){1'b0}};
      out_port  = {port_width{1'b0}};
    end
  end

`ifdef READ_DISTRIBUTOR_STATS_EN
  logic [15:0] stat_cnt_r [num_of_ports];

  // Per-channel completed-pop counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < num_of_ports; i++) begin
        stat_cnt_r[i] <= 16'h0000;
      end
    end else if (pop_s && (stat_cnt_r[head_port_s] != 16'hFFFF)) begin
      stat_cnt_r[head_port_s] <= stat_cnt_r[head_port_s] + 16'h0001;
    end else begin
      stat_cnt_r[head_port_s] <= stat_cnt_r[head_port_s];
    end
  end

  // Registered read port for the selected counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_count <= 16'h0000;
    end else begin
      stat_count <= stat_cnt_r[stat_sel];
    end
  end
`endif

endmodule

// File: doc/read_channel_distributor.md
Name: read_channel_distributor

Overview:
Read-side counterpart of the write-path channel selector. It takes one stream of SRAM read beats, each tagged with a destination port number, and buffers them in a small FIFO. Each beat is delivered to exactly one of num_of_ports output channels over a per-port valid/ready handshake. It sits between the SRAM read datapath and the per-port read interfaces.

Parameters:
- data_width, 256, width of one beat.
- num_of_ports, 16, number of output channels.
- port_width, 4, width of the port tag; equals log2(num_of_ports).
- fifo_depth, 4, number of buffered beats; must be a power of 2 and at least 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_port and in_data hold a beat.
- in_ready  output  1  block can accept a beat; equals !full.
- in_port  input  port_width  destination channel of the beat.
- in_data  input  data_width  beat payload.
- out_data  output  num_of_ports*data_width  flattened bus; slice j is bits [(j+1)*data_width-1 : j*data_width].
- out_valid  output  num_of_ports  one-hot (or all zero) valid per channel.
- out_ready  input  num_of_ports  per-channel ready.
- out_port  output  port_width  port tag of the FIFO head; 0 when empty.
- busy  output  1  FIFO is not empty.

Behaviour:
- Clock and reset:
  - Single clock domain on clk.
  - rst is synchronous and active-high. It is sampled on the rising clk edge and overrides every other action in that cycle.
- Reset state:
  - Write pointer, read pointer and count are all 0.
  - in_ready = 1, out_valid = 0, out_data = all 0, out_port = 0, busy = 0.
  - FIFO storage contents are don't-care after reset.
- Push:
  - Happens when in_valid && in_ready.
  - Writes {in_port, in_data} at the write pointer, then increments the write pointer modulo fifo_depth.
- Pop:
  - Happens when busy && out_ready[head_port].
  - Increments the read pointer modulo fifo_depth.
  - out_ready on non-selected channels is ignored.
- Output decode (combinational from the FIFO head and count):
  - out_valid[head_port] = busy; all other bits are 0.
  - Slice head_port of out_data = head data; all other slices = 0.
  - When empty, all slices = 0.
- Latency:
  - A beat pushed at edge N into an empty FIFO is visible on the outputs after edge N, i.e. in cycle N+1.
  - Zero bubbles when pops happen back-to-back.
- count:
  - Width is log2(fifo_depth)+1.
  - Push only: count+1. Pop only: count-1. Push and pop together: unchanged.
- Full:
  - count == fifo_depth gives in_ready = 0, so no push occurs.
  - A pop in that same cycle raises in_ready in the next cycle. There is no same-cycle pass-through.
- Empty:
  - No pop occurs regardless of out_ready.
  - A simultaneous push and pop cannot happen when the FIFO is empty.
- Ordering: strict FIFO order across all ports.
  - A stalled head, whose out_ready is low, blocks every beat behind it, including beats for other ports.
- Pointer wrap: both pointers wrap at fifo_depth-1 back to 0 with no gap.
- Handshake rule: while out_valid[j] is high and out_ready[j] is low, slice j of out_data and out_port must stay stable.
- Mid-operation reset: rst while beats are buffered discards all of them. Outputs return to the reset state in the cycle after the rst edge.
- Out-of-range tag: in_port >= num_of_ports is not possible with the defaults. For other configurations the beat is dropped at push: no write and no count change.

Optional Feature:
- Macro: READ_DISTRIBUTOR_STATS_EN.
- When defined:
  - Adds a per-channel 16-bit saturating counter of completed pops. A counter saturates at 0xFFFF.
  - Adds input stat_sel [port_width] and output stat_count [16]. stat_count is the counter selected by stat_sel, registered, so it has 1-cycle latency.
  - rst clears all counters.
- When not defined: no counters and no stat ports. Behaviour is otherwise identical.

Test Plan:
- Reset check: apply rst for 2 cycles and release -> in_ready=1, busy=0, out_valid=16'h0000, out_data=0, out_port=0.
- Single beat: push port 5, data 256'hA5..A5, with out_ready=16'hFFFF -> in the next cycle out_valid=16'h0020 and slice 5 = A5..A5; it pops that cycle; busy=0 the cycle after.
- Fill and stall: out_ready=0, push 4 beats (ports 1,2,3,4) -> in_ready=0 after the 4th push; a 5th beat is held off. Raise out_ready[1] only -> beat 1 pops and in_ready returns in the following cycle. Ports 2–4 wait until their ready bits go high.
- Head-of-line blocking: head for port 7 with out_ready[7]=0, all other ready bits =1 -> nothing pops and out_valid stays 16'h0080.
- Streaming and wrap: 100 random beats with random ports, random out_ready, in_valid always 1 -> the delivered sequence of {port, data} matches the pushed sequence exactly and pointers wrap more than 20 times.
- Mid-operation reset: rst with 3 beats buffered -> next cycle busy=0 and out_valid=0; the first post-reset push is the first beat delivered. With READ_DISTRIBUTOR_STATS_EN, counters read 0 after reset.
